// File: rtl/bitwise_logic_pipe_pkg.sv
// Shared types and the per-bit operation used by the bitwise_logic_pipe block.
// The optional transfer counter is enabled with LOGIC_PIPE_CNT_EN.
package logic_pipe_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOT  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    // Single-bit slice of the operation; the top replicates it across WIDTH.
    function automatic logic apply_op(op_e op, logic a, logic b);
        case (op)
            OP_NOT:  return ~a;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NAND: return ~(a & b);
            OP_NOR:  return ~(a | b);
            OP_XNOR: return ~(a ^ b);
            OP_PASS: return a;
            default: return a;
        endcase
    endfunction

endpackage

// File: rtl/bitwise_logic_pipe_if.sv
// Operand/result handshake bus for bitwise_logic_pipe.
// xfer_cnt exists only when LOGIC_PIPE_CNT_EN is defined.
interface bitwise_logic_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    import logic_pipe_pkg::*;

    logic              cfg_we;
    logic [OP_W-1:0]   op_sel;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  result;
    logic [OP_W-1:0]   op_cur;
`ifdef LOGIC_PIPE_CNT_EN
    logic [CNT_W-1:0]  xfer_cnt;

    modport master (output cfg_we, op_sel, in_valid, a, b, out_ready,
                    input  in_ready, out_valid, result, op_cur, xfer_cnt);
    modport slave  (input  cfg_we, op_sel, in_valid, a, b, out_ready,
                    output in_ready, out_valid, result, op_cur, xfer_cnt);
`else
    modport master (output cfg_we, op_sel, in_valid, a, b, out_ready,
                    input  in_ready, out_valid, result, op_cur);
    modport slave  (input  cfg_we, op_sel, in_valid, a, b, out_ready,
                    output in_ready, out_valid, result, op_cur);
`endif

endinterface

// File: rtl/bitwise_logic_pipe_stage.sv
// One valid+data register stage of the logic pipe; holds when i_en is low.
module logic_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_data
);

    logic             r_vld;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_data <= '0;
        end else if (i_en) begin
            r_vld  <= i_vld;
            r_data <= i_data;
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Runtime-selectable bitwise operation followed by a LATENCY-deep valid/ready pipe.
// Define LOGIC_PIPE_CNT_EN to add the wrapping output-transfer counter xfer_cnt.
module bitwise_logic_pipe
    import logic_pipe_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bitwise_logic_pipe_if.slave  bus
);

    op_e                         r_op;
    logic [WIDTH-1:0]            w_calc;
    logic                        w_adv;
    logic [LATENCY:0]            w_vld;
    logic [LATENCY:0][WIDTH-1:0] w_data;

    // The op register updates at the same edge a transfer is captured, so that
    // transfer still sees the old op.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_op <= OP_NOT;
        else if (bus.cfg_we)
            r_op <= op_e'(bus.op_sel);
    end

    always_comb begin
        w_calc = '0;
        for (int i = 0; i < WIDTH; i++)
            w_calc[i] = apply_op(r_op, bus.a[i], bus.b[i]);
    end

    // Whole pipe moves together; an empty output slot lets bubbles collapse.
    assign w_adv     = !w_vld[LATENCY] || bus.out_ready;
    assign w_vld[0]  = bus.in_valid;
    assign w_data[0] = w_calc;

    for (genvar g = 0; g < LATENCY; g++) begin : g_stage
        logic_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_en   (w_adv),
            .i_vld  (w_vld[g]),
            .i_data (w_data[g]),
            .o_vld  (w_vld[g+1]),
            .o_data (w_data[g+1])
        );
    end

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = w_vld[LATENCY];
    assign bus.result    = w_data[LATENCY];
    assign bus.op_cur    = r_op;

`ifdef LOGIC_PIPE_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (w_vld[LATENCY] && bus.out_ready)
            r_cnt <= r_cnt + CNT_ONE;
    end

    assign bus.xfer_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Directed, table-driven bench for bitwise_logic_pipe (WIDTH=8, LATENCY=2, CNT_W=4).
// Counter checks are active when LOGIC_PIPE_CNT_EN is defined.
module tb_bitwise_logic_pipe;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bitwise_logic_pipe_if #(.WIDTH(8), .CNT_W(4)) bus ();

    bitwise_logic_pipe #(.WIDTH(8), .LATENCY(2), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] op);
        bus.cfg_we = 1'b1;
        bus.op_sel = op;
        step();
        bus.cfg_we = 1'b0;
    endtask

    initial begin
        vec_t       vecs [8];
        logic [7:0] sv_in  [4];
        logic [7:0] held;
        int         in_idx, out_idx, fires;
        logic       in_fire, out_fire, stalled_prev;

        vecs[0] = '{3'd0, 8'hF0, 8'hCC, 8'h0F};
        vecs[1] = '{3'd1, 8'hF0, 8'hCC, 8'hC0};
        vecs[2] = '{3'd2, 8'hF0, 8'hCC, 8'hFC};
        vecs[3] = '{3'd3, 8'hF0, 8'hCC, 8'h3C};
        vecs[4] = '{3'd4, 8'hF0, 8'hCC, 8'h3F};
        vecs[5] = '{3'd5, 8'hF0, 8'hCC, 8'h03};
        vecs[6] = '{3'd6, 8'hF0, 8'hCC, 8'hC3};
        vecs[7] = '{3'd7, 8'hF0, 8'hCC, 8'hF0};

        bus.cfg_we = 1'b0; bus.op_sel = 3'd0; bus.in_valid = 1'b0;
        bus.a = 8'h00; bus.b = 8'h00; bus.out_ready = 1'b1;
        rst_n = 1'b0;

        // Reset: in_ready high throughout, defaults afterwards
        step();
        chk("in_ready_in_reset", 32'(bus.in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_op_cur",    32'(bus.op_cur),    32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
`ifdef LOGIC_PIPE_CNT_EN
        chk("rst_xfer_cnt",  32'(bus.xfer_cnt),  32'd0);
`endif

        // Default NOT with two-edge latency
        bus.in_valid = 1'b1; bus.a = 8'h5A;
        step();
        bus.in_valid = 1'b0;
        chk("not_lat_early", 32'(bus.out_valid), 32'd0);
        step();
        chk("not_lat_valid", 32'(bus.out_valid), 32'd1);
        chk("not_result",    32'(bus.result),    32'hA5);
        step();
        chk("not_drained",   32'(bus.out_valid), 32'd0);

        // All operations from the table
        foreach (vecs[i]) begin
            set_op(vecs[i].op);
            chk($sformatf("op_cur_%0d", i), 32'(bus.op_cur), 32'(vecs[i].op));
            bus.in_valid = 1'b1; bus.a = vecs[i].a; bus.b = vecs[i].b;
            step();
            bus.in_valid = 1'b0;
            chk($sformatf("op%0d_early", i), 32'(bus.out_valid), 32'd0);
            step();
            chk($sformatf("op%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("op%0d_result", i), 32'(bus.result), 32'(vecs[i].exp));
        end
        step();

        // cfg_we in the same cycle as a transfer: old op used for that transfer
        set_op(3'd1);
        bus.cfg_we = 1'b1; bus.op_sel = 3'd3;
        bus.in_valid = 1'b1; bus.a = 8'hF0; bus.b = 8'hCC;
        step();
        bus.cfg_we = 1'b0;
        chk("cfg_same_op_cur", 32'(bus.op_cur), 32'd3);
        step();
        bus.in_valid = 1'b0;
        chk("cfg_same_v1", 32'(bus.out_valid), 32'd1);
        chk("cfg_same_r1", 32'(bus.result),    32'hC0);
        step();
        chk("cfg_same_v2", 32'(bus.out_valid), 32'd1);
        chk("cfg_same_r2", 32'(bus.result),    32'h3C);
        step();

        // Backpressure: PASS stream with out_ready low for cycles 3..5
        set_op(3'd7);
        sv_in[0] = 8'h11; sv_in[1] = 8'h22; sv_in[2] = 8'h33; sv_in[3] = 8'h44;
        in_idx = 0; out_idx = 0; stalled_prev = 1'b0; held = 8'h00;
        for (int c = 0; c < 16; c++) begin
            bus.in_valid  = (in_idx < 4);
            bus.a         = (in_idx < 4) ? sv_in[in_idx] : 8'h00;
            bus.out_ready = !(c >= 3 && c <= 5);
            #1;
            in_fire  = bus.in_valid && bus.in_ready;
            out_fire = bus.out_valid && bus.out_ready;
            if (bus.out_valid && !bus.out_ready) begin
                chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
                if (stalled_prev)
                    chk("bp_result_held", 32'(bus.result), 32'(held));
                held = bus.result;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (out_fire) begin
                if (out_idx < 4)
                    chk($sformatf("bp_order_%0d", out_idx), 32'(bus.result), 32'(sv_in[out_idx]));
                else
                    chk("bp_extra_output", 32'(out_idx), 32'd3);
                out_idx++;
            end
            if (in_fire) in_idx++;
            step();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        chk("bp_out_count", 32'(out_idx), 32'd4);
        chk("bp_in_count",  32'(in_idx),  32'd4);

`ifdef LOGIC_PIPE_CNT_EN
        // 17 output transfers wrap a 4-bit counter to 1
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_op(3'd7);
        fires = 0;
        for (int c = 0; c < 20; c++) begin
            bus.in_valid = (c < 17);
            bus.a = 8'(c);
            #1;
            if (bus.out_valid && bus.out_ready) fires++;
            step();
        end
        bus.in_valid = 1'b0;
        chk("cnt_fires", 32'(fires), 32'd17);
        chk("cnt_wrap",  32'(bus.xfer_cnt), 32'd1);
`endif

        // Reset mid-stream discards in-flight data and the op register
        set_op(3'd2);
        bus.in_valid = 1'b1; bus.a = 8'h0F; bus.b = 8'hF0;
        step();
        step();
        chk("mid_pre_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        step();
        chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_op_cur",    32'(bus.op_cur),    32'd0);
`ifdef LOGIC_PIPE_CNT_EN
        chk("mid_xfer_cnt",  32'(bus.xfer_cnt),  32'd0);
`endif
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        step();
        chk("post_rst_empty", 32'(bus.out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
